// File: rtl/lsu_req_arb.sv
// Shares one LSU request/done channel between NumReq requesters with round-robin
// arbitration: zero-latency grant from IDLE, then locked until done or owner flush.
module lsu_req_arb #(
    parameter int unsigned  NumReq     = 2,
    parameter bit           Prio0Fixed = 1'b0,
    parameter int unsigned  InfoW      = 64,
    localparam int unsigned IdW        = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NumReq-1:0]            req_valid_i,
    input  logic [NumReq-1:0][InfoW-1:0] req_info_i,
    input  logic [NumReq-1:0]            flush_i,
    output logic [NumReq-1:0]            req_done_o,
    output logic                         lsu_req_o,
    output logic [InfoW-1:0]             lsu_req_info_o,
    input  logic                         lsu_req_done_i,
    output logic [IdW-1:0]               gnt_id_o
);

    localparam logic [InfoW-1:0] NULL_LSU_REQ_INFO = '0;
    localparam logic [IdW-1:0]   LAST_ID           = IdW'(NumReq - 1);
    localparam logic [IdW:0]     NUM_REQ_W         = (IdW + 1)'(NumReq);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e            state_q;
    logic [IdW-1:0]    rr_ptr_q;
    logic [IdW-1:0]    owner_q;

    logic [NumReq-1:0] elig;
    logic              any_elig;
    logic [IdW-1:0]    winner;
    logic [IdW:0]      scan;
    logic              found;

    // Compare-and-wrap so unused pointer codes can never be reached.
    function automatic logic [IdW-1:0] next_id(input logic [IdW-1:0] id);
        return (id == LAST_ID) ? '0 : id + IdW'(1);
    endfunction

    assign elig     = req_valid_i & ~flush_i;
    assign any_elig = |elig;

    always_comb begin
        winner = rr_ptr_q;
        found  = 1'b0;
        scan   = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            scan = {1'b0, rr_ptr_q} + (IdW + 1)'(k);
            if (scan >= NUM_REQ_W) begin
                scan = scan - NUM_REQ_W;
            end
            if (!found && elig[scan[IdW-1:0]]) begin
                winner = scan[IdW-1:0];
                found  = 1'b1;
            end
        end
        if (Prio0Fixed && elig[0]) begin
            winner = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_elig) begin
                        if (lsu_req_done_i) begin
                            rr_ptr_q <= next_id(winner);
                        end else begin
                            owner_q <= winner;
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (flush_i[owner_q] || lsu_req_done_i) begin
                        rr_ptr_q <= next_id(owner_q);
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs are combinational so the IDLE grant costs no cycle; reset forces them quiet.
    always_comb begin
        lsu_req_o      = 1'b0;
        lsu_req_info_o = NULL_LSU_REQ_INFO;
        gnt_id_o       = '0;
        req_done_o     = '0;
        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    gnt_id_o = rr_ptr_q;
                    if (any_elig) begin
                        lsu_req_o      = 1'b1;
                        lsu_req_info_o = req_info_i[winner];
                        gnt_id_o       = winner;
                        if (lsu_req_done_i) begin
                            req_done_o[winner] = 1'b1;
                        end
                    end
                end
                BUSY: begin
                    gnt_id_o       = owner_q;
                    lsu_req_info_o = req_info_i[owner_q];
                    if (!flush_i[owner_q]) begin
                        lsu_req_o = 1'b1;
                        if (lsu_req_done_i) begin
                            req_done_o[owner_q] = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    a_owner_holds_valid: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == BUSY && !flush_i[owner_q]) |-> req_valid_i[owner_q]);

    a_done_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(req_done_o));

endmodule

// File: tb/tb_lsu_req_arb.sv
// Directed bench for lsu_req_arb: round-robin (2 and 3 requesters) and fixed-priority
// instances driven from hand-written vector tables with hand-computed expectations.
module tb_lsu_req_arb;

    typedef struct packed {
        logic [1:0]  v;
        logic [1:0]  f;
        logic        ld;
        logic        lr;
        logic [0:0]  g;
        logic [1:0]  rd;
        logic [15:0] io;
    } vec2_t;

    typedef struct packed {
        logic [2:0]  v;
        logic        ld;
        logic        lr;
        logic [1:0]  g;
        logic [2:0]  rd;
        logic [15:0] io;
    } vec3_t;

    int n_pass  = 0;
    int n_total = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Round-robin, 2 requesters
    logic [1:0]       v2 = '0, f2 = '0, rd2;
    logic [1:0][15:0] in2;
    logic             ld2 = 1'b0, lr2;
    logic [15:0]      io2;
    logic [0:0]       g2;

    // Requester 0 fixed priority, 2 requesters
    logic [1:0]       vp = '0, fp = '0, rdp;
    logic [1:0][15:0] inp;
    logic             ldp = 1'b0, lrp;
    logic [15:0]      iop;
    logic [0:0]       gp;

    // Round-robin, 3 requesters
    logic [2:0]       v3 = '0, f3 = '0, rd3;
    logic [2:0][15:0] in3;
    logic             ld3 = 1'b0, lr3;
    logic [15:0]      io3;
    logic [1:0]       g3;

    always #5 clk = ~clk;

    lsu_req_arb #(.NumReq(2), .Prio0Fixed(1'b0), .InfoW(16)) u_rr2 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(v2), .req_info_i(in2), .flush_i(f2),
        .req_done_o(rd2), .lsu_req_o(lr2), .lsu_req_info_o(io2),
        .lsu_req_done_i(ld2), .gnt_id_o(g2)
    );

    lsu_req_arb #(.NumReq(2), .Prio0Fixed(1'b1), .InfoW(16)) u_fix2 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(vp), .req_info_i(inp), .flush_i(fp),
        .req_done_o(rdp), .lsu_req_o(lrp), .lsu_req_info_o(iop),
        .lsu_req_done_i(ldp), .gnt_id_o(gp)
    );

    lsu_req_arb #(.NumReq(3), .Prio0Fixed(1'b0), .InfoW(16)) u_rr3 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(v3), .req_info_i(in3), .flush_i(f3),
        .req_done_o(rd3), .lsu_req_o(lr3), .lsu_req_info_o(io3),
        .lsu_req_done_i(ld3), .gnt_id_o(g3)
    );

    task automatic test_reset();
        @(negedge clk);
        v2 = 2'b11; ld2 = 1'b1;
        #1;
        n_total++;
        if ({lr2, g2, rd2, io2} !== {1'b0, 1'b0, 2'b00, 16'h0000})
            $display("FAIL reset_hold lr=%0b g=%0d rd=%b io=%h exp lr=0 g=0 rd=00 io=0000",
                     lr2, g2, rd2, io2);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0; v2 = '0; ld2 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_total++;
            if ({lr2, rd2, lrp, rdp, lr3, rd3} !== 10'b0)
                $display("FAIL reset_idle c%0d lr=%b%b%b rd=%b %b %b exp all 0",
                         i, lr2, lrp, lr3, rd2, rdp, rd3);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_alternate();
        for (int i = 0; i < 4; i++) begin
            v2 = 2'b11; f2 = 2'b00; ld2 = 1'b1;
            #1;
            n_total++;
            if ({lr2, g2, rd2} !== {1'b1, 1'((i % 2)), ((i % 2) == 1) ? 2'b10 : 2'b01})
                $display("FAIL alternate c%0d lr=%0b g=%0d rd=%b exp lr=1 g=%0d rd=%s",
                         i, lr2, g2, rd2, i % 2, ((i % 2) == 1) ? "10" : "01");
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_hold();
        vec2_t tbl [6];
        tbl = '{
            '{2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 16'hB111},
            '{2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 16'hB111},
            '{2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 16'hB111},
            '{2'b11, 2'b00, 1'b1, 1'b1, 1'b1, 2'b10, 16'hB111},
            '{2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 2'b01, 16'hA000},
            '{2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 16'h0000}
        };
        for (int i = 0; i < 6; i++) begin
            v2 = tbl[i].v; f2 = tbl[i].f; ld2 = tbl[i].ld;
            #1;
            n_total++;
            if ({lr2, g2, rd2, io2} !== {tbl[i].lr, tbl[i].g, tbl[i].rd, tbl[i].io})
                $display("FAIL hold c%0d lr=%0b g=%0d rd=%b io=%h exp lr=%0b g=%0d rd=%b io=%h",
                         i, lr2, g2, rd2, io2, tbl[i].lr, tbl[i].g, tbl[i].rd, tbl[i].io);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_flush();
        vec2_t tbl [7];
        tbl = '{
            '{2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 16'hA000},
            '{2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 16'hA000},
            '{2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 16'hB111},
            '{2'b11, 2'b01, 1'b0, 1'b1, 1'b1, 2'b00, 16'hB111},
            '{2'b11, 2'b00, 1'b1, 1'b1, 1'b1, 2'b10, 16'hB111},
            '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000},
            '{2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0000}
        };
        for (int i = 0; i < 7; i++) begin
            v2 = tbl[i].v; f2 = tbl[i].f; ld2 = tbl[i].ld;
            #1;
            n_total++;
            if ({lr2, g2, rd2, io2} !== {tbl[i].lr, tbl[i].g, tbl[i].rd, tbl[i].io})
                $display("FAIL flush c%0d lr=%0b g=%0d rd=%b io=%h exp lr=%0b g=%0d rd=%b io=%h",
                         i, lr2, g2, rd2, io2, tbl[i].lr, tbl[i].g, tbl[i].rd, tbl[i].io);
            else n_pass++;
            @(negedge clk);
        end
        v2 = '0; f2 = '0; ld2 = 1'b0;
    endtask

    task automatic test_prio0();
        vec2_t tbl [6];
        tbl = '{
            '{2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 2'b01, 16'hA000},
            '{2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 2'b01, 16'hA000},
            '{2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 2'b01, 16'hA000},
            '{2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 2'b01, 16'hA000},
            '{2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 2'b10, 16'hB111},
            '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000}
        };
        for (int i = 0; i < 6; i++) begin
            vp = tbl[i].v; fp = tbl[i].f; ldp = tbl[i].ld;
            #1;
            n_total++;
            if ({lrp, gp, rdp, iop} !== {tbl[i].lr, tbl[i].g, tbl[i].rd, tbl[i].io})
                $display("FAIL prio0 c%0d lr=%0b g=%0d rd=%b io=%h exp lr=%0b g=%0d rd=%b io=%h",
                         i, lrp, gp, rdp, iop, tbl[i].lr, tbl[i].g, tbl[i].rd, tbl[i].io);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_wrap_rst();
        vec3_t tbl [5];
        tbl = '{
            '{3'b010, 1'b1, 1'b1, 2'd1, 3'b010, 16'hC001},
            '{3'b011, 1'b1, 1'b1, 2'd0, 3'b001, 16'hC000},
            '{3'b011, 1'b1, 1'b1, 2'd1, 3'b010, 16'hC001},
            '{3'b011, 1'b0, 1'b1, 2'd0, 3'b000, 16'hC000},
            '{3'b011, 1'b0, 1'b1, 2'd0, 3'b000, 16'hC000}
        };
        for (int i = 0; i < 5; i++) begin
            v3 = tbl[i].v; ld3 = tbl[i].ld;
            #1;
            n_total++;
            if ({lr3, g3, rd3, io3} !== {tbl[i].lr, tbl[i].g, tbl[i].rd, tbl[i].io})
                $display("FAIL wrap c%0d lr=%0b g=%0d rd=%b io=%h exp lr=%0b g=%0d rd=%b io=%h",
                         i, lr3, g3, rd3, io3, tbl[i].lr, tbl[i].g, tbl[i].rd, tbl[i].io);
            else n_pass++;
            @(negedge clk);
        end
        // Owner 0 is BUSY here; reset must drop it at once with no done.
        rst = 1'b1; ld3 = 1'b1;
        #1;
        n_total++;
        if ({lr3, g3, rd3, io3} !== {1'b0, 2'd0, 3'b000, 16'h0000})
            $display("FAIL rst_busy lr=%0b g=%0d rd=%b io=%h exp lr=0 g=0 rd=000 io=0000",
                     lr3, g3, rd3, io3);
        else n_pass++;
        @(negedge clk);
        #1;
        n_total++;
        if ({lr3, rd3} !== {1'b0, 3'b000})
            $display("FAIL rst_held lr=%0b rd=%b exp lr=0 rd=000", lr3, rd3);
        else n_pass++;
        rst = 1'b0; v3 = '0; ld3 = 1'b0;
        #1;
        n_total++;
        if ({lr3, g3, rd3} !== {1'b0, 2'd0, 3'b000})
            $display("FAIL rst_release lr=%0b g=%0d rd=%b exp lr=0 g=0 rd=000", lr3, g3, rd3);
        else n_pass++;
        @(negedge clk);
        v3 = 3'b010; ld3 = 1'b1;
        #1;
        n_total++;
        if ({lr3, g3, rd3, io3} !== {1'b1, 2'd1, 3'b010, 16'hC001})
            $display("FAIL rst_regrant lr=%0b g=%0d rd=%b io=%h exp lr=1 g=1 rd=010 io=c001",
                     lr3, g3, rd3, io3);
        else n_pass++;
        @(negedge clk);
        v3 = '0; ld3 = 1'b0;
    endtask

    initial begin
        in2[0] = 16'hA000; in2[1] = 16'hB111;
        inp[0] = 16'hA000; inp[1] = 16'hB111;
        in3[0] = 16'hC000; in3[1] = 16'hC001; in3[2] = 16'hC002;
        test_reset();
        test_alternate();
        test_hold();
        test_flush();
        test_prio0();
        test_wrap_rst();
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
